stream_demultiplexer: RTL and testbench

Receive-side counterpart of the 3-stream serial multiplexer. Recovers the per-stream bytes from the serial line, the frame-sync qualifier and the bit clock `sclk`, and presents them as parallel words `ds1`/`ds2`/`ds3` with per-channel valid pulses. Runs entirely in the `clk` domain: `sclk` is treated as asynchronous and edge-detected, never used as a clock. Sits between the serial link and downstream stream consumers.

---
 rtl/stream_demultiplexer_pkg.sv | 20 ++
 rtl/stream_demultiplexer_if.sv | 32 +++
 rtl/stream_demultiplexer_sclk_edge_sync.sv | 42 ++++
 rtl/stream_demultiplexer.sv | 129 ++++++++++++
 tb/tb_stream_demultiplexer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demultiplexer_pkg.sv
// Shared definitions for the 3-stream serial demultiplexer: slot width,
// channel-count encodings and the receive FSM state type.
package demux_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_1CH = 2'd1,
        MODE_2CH = 2'd2,
        MODE_3CH = 2'd3
    } demux_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } demux_state_e;

endpackage

// File: rtl/stream_demultiplexer_if.sv
// Serial-link inputs and parallel word outputs of the stream demultiplexer.
// The master side (link/transmitter) drives sclk/sdata/sync/mode; the slave
// side (demux) drives the words, their qualifiers and the debug state.
interface stream_demultiplexer_if
    import demux_pkg::*;
#(
    parameter int DATA_W = demux_pkg::DATA_W
);
    logic              sclk;
    logic              sdata;
    logic              sync;
    logic [1:0]        mode;
    // No backpressure: ds1..ds3 are valid whenever the matching ch_valid bit
    // pulses for one clk; out_ready and frame_err are single-clk events.
    logic [DATA_W-1:0] ds1;
    logic [DATA_W-1:0] ds2;
    logic [DATA_W-1:0] ds3;
    logic [2:0]        ch_valid;
    logic              out_ready;
    logic              frame_err;
    demux_state_e      dbg_state;

    modport master (
        output sclk, sdata, sync, mode,
        input  ds1, ds2, ds3, ch_valid, out_ready, frame_err, dbg_state
    );

    modport slave (
        input  sclk, sdata, sync, mode,
        output ds1, ds2, ds3, ch_valid, out_ready, frame_err, dbg_state
    );
endinterface

// File: rtl/stream_demultiplexer_sclk_edge_sync.sv
// Brings the asynchronous serial bit clock, data and sync into the clk domain
// and turns each sclk rising edge into a one-clk bit strobe with aligned data.
module sclk_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic sdata,
    input  logic sync,
    output logic bit_stb,
    output logic bit_d,
    output logic sync_d
);
    logic [2:0] sclk_q;
    logic [1:0] sdata_q;
    logic [1:0] sync_q;
    logic       bit_stb_q;
    logic       bit_d_q;
    logic       sync_d_q;

    // sdata/sync use the same depth as sclk so the sampled bit matches the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q    <= '0;
            sdata_q   <= '0;
            sync_q    <= '0;
            bit_stb_q <= 1'b0;
            bit_d_q   <= 1'b0;
            sync_d_q  <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[1:0], sclk};
            sdata_q   <= {sdata_q[0], sdata};
            sync_q    <= {sync_q[0], sync};
            bit_stb_q <= sclk_q[1] & ~sclk_q[2];
            bit_d_q   <= sdata_q[1];
            sync_d_q  <= sync_q[1];
        end
    end

    assign bit_stb = bit_stb_q;
    assign bit_d   = bit_d_q;
    assign sync_d  = sync_d_q;
endmodule

// File: rtl/stream_demultiplexer.sv
// Receive side of the 3-stream serial multiplexer: deserialises MSB-first
// slots into ds1..ds3 under a frame FSM advanced by recovered sclk edges.
module stream_demultiplexer
    import demux_pkg::*;
#(
    parameter int DATA_W = demux_pkg::DATA_W
) (
    input logic                   clk,
    input logic                   rst,
    stream_demultiplexer_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic bit_stb;
    logic bit_d;
    logic sync_d;

    sclk_edge_sync u_sclk_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .sclk    (bus.sclk),
        .sdata   (bus.sdata),
        .sync    (bus.sync),
        .bit_stb (bit_stb),
        .bit_d   (bit_d),
        .sync_d  (sync_d)
    );

    demux_state_e      state_q;
    logic [1:0]        nch_q;
    logic [1:0]        slot_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] ds1_q;
    logic [DATA_W-1:0] ds2_q;
    logic [DATA_W-1:0] ds3_q;
    logic [2:0]        ch_valid_q;
    logic              out_ready_q;
    logic              frame_err_q;

    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] first_bit_d;
    logic              word_last;

    assign shift_d     = {shift_q[DATA_W-2:0], bit_d};
    assign first_bit_d = {{(DATA_W - 1){1'b0}}, bit_d};
    assign word_last   = (bit_cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            nch_q       <= '0;
            slot_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ds1_q       <= '0;
            ds2_q       <= '0;
            ds3_q       <= '0;
            ch_valid_q  <= '0;
            out_ready_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ch_valid_q  <= '0;
            out_ready_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bit_stb && sync_d && (bus.mode != MODE_OFF)) begin
                        nch_q     <= bus.mode;
                        shift_q   <= first_bit_d;
                        bit_cnt_q <= CNT_W'(1);
                        slot_q    <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_stb) begin
                        if (sync_d) begin
                            // Resync: the partial word is dropped and this bit opens a new frame.
                            frame_err_q <= 1'b1;
                            nch_q       <= bus.mode;
                            shift_q     <= first_bit_d;
                            bit_cnt_q   <= CNT_W'(1);
                            slot_q      <= '0;
                            state_q     <= (bus.mode != MODE_OFF) ? ST_SHIFT : ST_IDLE;
                        end else if (word_last) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= '0;
                            slot_q    <= slot_q + 2'd1;
                            case (slot_q)
                                2'd0: begin
                                    ds1_q      <= shift_d;
                                    ch_valid_q <= 3'b001;
                                end
                                2'd1: begin
                                    ds2_q      <= shift_d;
                                    ch_valid_q <= 3'b010;
                                end
                                default: begin
                                    ds3_q      <= shift_d;
                                    ch_valid_q <= 3'b100;
                                end
                            endcase
                            if ((slot_q + 2'd1) == nch_q) begin
                                state_q <= ST_DONE;
                            end
                        end else begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    out_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ds1       = ds1_q;
    assign bus.ds2       = ds2_q;
    assign bus.ds3       = ds3_q;
    assign bus.ch_valid  = ch_valid_q;
    assign bus.out_ready = out_ready_q;
    assign bus.frame_err = frame_err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_stream_demultiplexer.sv
// Directed and randomized frames for the stream demultiplexer, checked against
// a frame-level model of which channel words must appear and in what order.
module tb_stream_demultiplexer;
    import demux_pkg::*;

    localparam int W = demux_pkg::DATA_W;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ready_cnt;
    int   ferr_cnt;

    logic [W+1:0] exp_q[$];
    logic [W-1:0] exp_ds[3];

    stream_demultiplexer_if bus ();

    stream_demultiplexer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [W-1:0] ds_of(input int c);
        case (c)
            0:       return bus.ds1;
            1:       return bus.ds2;
            default: return bus.ds3;
        endcase
    endfunction

    // Scoreboard: every ch_valid bit must match the next expected channel word.
    always @(negedge clk) begin
        if (bus.out_ready === 1'b1) ready_cnt++;
        if (bus.frame_err === 1'b1) ferr_cnt++;
        for (int c = 0; c < 3; c++) begin
            if (bus.ch_valid[c] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("ch_valid_unexpected", 32'(bus.ch_valid), 32'(0));
                end else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    check("ch_valid_channel", 32'(c), 32'(e[W+1:W]));
                    check("ds_word", 32'(ds_of(c)), 32'(e[W-1:0]));
                end
            end
        end
    end

    task automatic check_ds();
        check("ds1_final", 32'(bus.ds1), 32'(exp_ds[0]));
        check("ds2_final", 32'(bus.ds2), 32'(exp_ds[1]));
        check("ds3_final", 32'(bus.ds3), 32'(exp_ds[2]));
    endtask

    // ---------------- model ----------------
    task automatic expect_word(input int ch, input logic [W-1:0] w);
        exp_q.push_back({2'(ch), w});
        exp_ds[ch] = w;
    endtask

    // ---------------- drivers ----------------
    task automatic tx_bit(input logic b, input logic s);
        bus.sdata = b;
        bus.sync  = s;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b0;
    endtask

    task automatic tx_word(input logic [W-1:0] w, input logic first_sync);
        for (int i = W - 1; i >= 0; i--) begin
            tx_bit(w[i], first_sync && (i == W - 1));
        end
    endtask

    task automatic send_frame(input logic [1:0] m, input logic [W-1:0] b0,
                              input logic [W-1:0] b1, input logic [W-1:0] b2);
        logic [W-1:0] bytes[3];
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        bus.mode = m;
        for (int i = 0; i < int'(m); i++) expect_word(i, bytes[i]);
        for (int i = 0; i < int'(m); i++) tx_word(bytes[i], i == 0);
    endtask

    task automatic wait_ready(input int target);
        int n;
        n = 0;
        while (ready_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_ready_count", 32'(ready_cnt), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ds1"}, 32'(bus.ds1), 32'(0));
        check({tag, "_ds2"}, 32'(bus.ds2), 32'(0));
        check({tag, "_ds3"}, 32'(bus.ds3), 32'(0));
        check({tag, "_ch_valid"}, 32'(bus.ch_valid), 32'(0));
        check({tag, "_out_ready"}, 32'(bus.out_ready), 32'(0));
        check({tag, "_frame_err"}, 32'(bus.frame_err), 32'(0));
        check({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           base;
        logic [W-1:0] r0;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [W-1:0] r3;
        logic [1:0]   m;

        checks    = 0;
        errors    = 0;
        ready_cnt = 0;
        ferr_cnt  = 0;
        for (int i = 0; i < 3; i++) exp_ds[i] = '0;
        rst       = 1'b0;
        bus.sclk  = 1'b0;
        bus.sdata = 1'b0;
        bus.sync  = 1'b0;
        bus.mode  = MODE_OFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Full 3-channel frame.
        send_frame(MODE_3CH, 8'hA5, 8'h3C, 8'hF0);
        wait_ready(1);
        check_ds();

        // 1-channel frame leaves ds2/ds3 untouched.
        send_frame(MODE_3CH, 8'h00, 8'h11, 8'h22);
        wait_ready(2);
        send_frame(MODE_1CH, 8'h81, 8'h00, 8'h00);
        wait_ready(3);
        check_ds();

        // Sync reasserted at bit 4 of slot 2, then a clean 2-channel frame.
        base = ferr_cnt;
        r0 = W'($urandom);
        bus.mode = MODE_2CH;
        expect_word(0, r0);
        tx_word(r0, 1'b1);
        for (int i = 0; i < 4; i++) tx_bit(1'($urandom), 1'b0);
        send_frame(MODE_2CH, 8'h55, 8'hAA, 8'h00);
        wait_ready(4);
        check("frame_err_count", 32'(ferr_cnt - base), 32'(1));
        check_ds();

        // Disabled mode: sync pulses and random data produce nothing.
        bus.mode = MODE_OFF;
        for (int i = 0; i < 24; i++) tx_bit(1'($urandom), (i % 8) == 0);
        repeat (20) @(negedge clk);
        check("mode_off_ready", 32'(ready_cnt), 32'(4));
        check_ds();

        // Reset during slot 2 of a 3-channel frame.
        r0 = W'($urandom);
        bus.mode = MODE_3CH;
        expect_word(0, r0);
        tx_word(r0, 1'b1);
        for (int i = 0; i < 3; i++) tx_bit(1'($urandom), 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        check("scoreboard_drained_at_reset", 32'(exp_q.size()), 32'(0));
        for (int i = 0; i < 3; i++) exp_ds[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(MODE_3CH, 8'h01, 8'h02, 8'h03);
        wait_ready(5);
        check_ds();

        // Back-to-back frames; mode drops to 1 during the first one.
        r0 = W'($urandom);
        r1 = W'($urandom);
        r2 = W'($urandom);
        r3 = W'($urandom);
        bus.mode = MODE_3CH;
        expect_word(0, r0);
        expect_word(1, r1);
        expect_word(2, r2);
        expect_word(0, r3);
        tx_word(r0, 1'b1);
        bus.mode = MODE_1CH;
        tx_word(r1, 1'b0);
        tx_word(r2, 1'b0);
        tx_word(r3, 1'b1);
        wait_ready(7);
        check_ds();

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            m = 2'($urandom_range(1, 3));
            send_frame(m, W'($urandom), W'($urandom), W'($urandom));
            wait_ready(8 + f);
        end
        check_ds();
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        check("frame_err_total", 32'(ferr_cnt), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
